// File: rtl/operand_fetch.sv
// Operand fetch for ARM data-processing instructions: reads Rn, Rm and Rs
// through a single register-file read port, one read per state.
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  output logic [3:0]  rf_ra,
  input  logic [31:0] rf_rd,
  output logic        busy,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] srca,
  output logic [31:0] firstvalue,
  output logic [4:0]  shammt,
  output logic [1:0]  sh,
  output logic        imm
);

  typedef enum logic [2:0] {IDLE, RD_RN, RD_RM, RD_RS, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] instr_q;
  logic [31:0] imm32;
  logic [4:0]  rot_amt;
  logic [31:0] imm_rot;
  logic        unused_bits;

  // Condition/opcode/S bits are decoded elsewhere; only bit 25 matters here.
  assign unused_bits = ^{instr_q[31:26], instr_q[24:20]};

  // ARM immediate: imm8 rotated right by twice the 4-bit rotate field.
  assign imm32   = {24'b0, instr_q[7:0]};
  assign rot_amt = {instr_q[11:8], 1'b0};
  assign imm_rot = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rf_ra     = 4'd0;
    busy      = 1'b1;
    op_valid  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RD_RN;
      end
      RD_RN: begin
        rf_ra     = instr_q[19:16];
        state_nxt = instr_q[25] ? DONE : RD_RM;
      end
      RD_RM: begin
        rf_ra     = instr_q[3:0];
        state_nxt = instr_q[4] ? RD_RS : DONE;
      end
      RD_RS: begin
        rf_ra     = instr_q[11:8];
        state_nxt = DONE;
      end
      DONE: begin
        op_valid = 1'b1;
        if (op_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers only move while their read state is active, so they
  // hold through DONE and IDLE until the next fetch overwrites them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= '0;
      srca       <= '0;
      firstvalue <= '0;
      shammt     <= '0;
      sh         <= '0;
      imm        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) instr_q <= instr;
        RD_RN: begin
          srca <= rf_rd;
          imm  <= instr_q[25];
          if (instr_q[25]) begin
            firstvalue <= imm_rot;
            shammt     <= 5'd0;
            sh         <= 2'b00;
          end
        end
        RD_RM: begin
          firstvalue <= rf_rd;
          sh         <= instr_q[6:5];
          if (!instr_q[4]) shammt <= instr_q[11:7];
        end
        RD_RS: shammt <= rf_rd[4:0];
        default: ;
      endcase
    end
  end

endmodule
